// File: rtl/pll_phase_pkg.sv
// Shared definitions for the PLL dynamic-phase-shift sequencer: command op-codes,
// FSM state encoding and the phase resolution of one PLL step.
package pll_phase_pkg;

  localparam int unsigned OP_W    = 2;
  localparam int unsigned PHASE_W = 8;

  localparam logic [OP_W-1:0] OP_STEP_DOWN = 2'd0;
  localparam logic [OP_W-1:0] OP_STEP_UP   = 2'd1;
  localparam logic [OP_W-1:0] OP_SET       = 2'd2;
  localparam logic [OP_W-1:0] OP_RESET     = 2'd3;

  // One phasestep handshake moves the PLL output by this many degrees.
  localparam real PHASE_DEG_PER_STEP = 4.5;

  typedef enum logic [2:0] {
    IDLE,
    PLAN,
    ASSERT,
    WAIT_LOW,
    WAIT_HIGH,
    FINISH
  } state_t;

endpackage

// File: rtl/pll_phase_step.sv
// Single phasestep/phasedone handshake with the altpll. PHASE_TIMEOUT_EN adds a
// watchdog that abandons a step whose phasedone never completes.
module pll_phase_step
  import pll_phase_pkg::*;
#(
  parameter int unsigned STEP_HOLD      = 5,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic up,
  input  logic phasedone,
  output logic phasestep,
  output logic phaseupdown,
  output logic done,
  output logic fail
);

  localparam int unsigned HOLD_W = $clog2(STEP_HOLD + 1);

  if (STEP_HOLD < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("pll_phase_step: illegal STEP_HOLD or TIMEOUT_CYCLES");
  end

  state_t            state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
  logic              seen_low, seen_low_next;

  assign done = (state == WAIT_HIGH) && phasedone;

`ifdef PHASE_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Watchdog restarts on every ASSERT entry and saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state != ASSERT && state_next == ASSERT) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt < TMO_W'(TIMEOUT_CYCLES)) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign fail = ((state == WAIT_LOW) || (state == WAIT_HIGH && !phasedone)) &&
                (tmo_cnt >= TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign fail = 1'b0;
`endif

  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    seen_low_next = seen_low;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next    = ASSERT;
          hold_cnt_next = '0;
          seen_low_next = 1'b0;
        end
      end
      ASSERT: begin
        hold_cnt_next = hold_cnt + HOLD_W'(1);
        if (!phasedone) seen_low_next = 1'b1;
        if (hold_cnt == HOLD_W'(STEP_HOLD - 1)) begin
          state_next = seen_low_next ? WAIT_HIGH : WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (fail)            state_next = IDLE;
        else if (!phasedone) state_next = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        // A back-to-back start goes straight into the next pulse.
        if (done) begin
          if (start) begin
            state_next    = ASSERT;
            hold_cnt_next = '0;
            seen_low_next = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end else if (fail) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      seen_low    <= 1'b0;
      phasestep   <= 1'b0;
      phaseupdown <= 1'b0;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_cnt_next;
      seen_low  <= seen_low_next;
      phasestep <= (state_next == ASSERT);
      if (start) phaseupdown <= up;
    end
  end

endmodule

// File: rtl/pll_phase_sequencer.sv
// Phase command sequencer for the altpll dynamic-phase-shift port. Build with
// PHASE_TIMEOUT_EN to enable the per-step phasedone watchdog and timeout_err.
module pll_phase_sequencer
  import pll_phase_pkg::*;
#(
  parameter int unsigned STEP_HOLD      = 5,
  parameter int unsigned MAX_STEPS      = 80,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       rx_clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_value,
  input  logic       phasedone,
  output logic       phasestep,
  output logic       phaseupdown,
  output logic [7:0] phase_value,
  output logic       busy,
  output logic       cmd_done,
  output logic       saturated,
  output logic       timeout_err
);

  localparam logic signed [PHASE_W:0] MAX_POS = (PHASE_W+1)'(MAX_STEPS);
  localparam logic signed [PHASE_W:0] MAX_NEG = -MAX_POS;

  if (MAX_STEPS < 1 || MAX_STEPS > 127) begin : g_param_check
    $error("pll_phase_sequencer: MAX_STEPS out of range");
  end

  state_t                   state, state_next;
  logic [OP_W-1:0]          op_q;
  logic [PHASE_W-1:0]       value_q;
  logic [PHASE_W-1:0]       remaining;
  logic signed [PHASE_W:0]  pv_c, target_raw_c, target_c, diff_c;
  logic                     plan_sat_c, plan_up_c;
  logic [PHASE_W-1:0]       plan_rem_c;
  logic                     accept_c, step_start_c, step_up_c, step_done, step_fail;

  assign accept_c  = (state == IDLE) && cmd_valid && cmd_ready;
  assign pv_c      = {phase_value[PHASE_W-1], phase_value};
  assign step_up_c = (state == PLAN) ? plan_up_c : phaseupdown;

  // Target, clamp and step count in 9-bit signed arithmetic.
  always_comb begin
    case (op_q)
      OP_STEP_DOWN: target_raw_c = pv_c - (PHASE_W+1)'(1);
      OP_STEP_UP:   target_raw_c = pv_c + (PHASE_W+1)'(1);
      OP_SET:       target_raw_c = {value_q[PHASE_W-1], value_q};
      default:      target_raw_c = '0;
    endcase
    plan_sat_c = 1'b0;
    target_c   = target_raw_c;
    if (target_raw_c > MAX_POS) begin
      target_c   = MAX_POS;
      plan_sat_c = 1'b1;
    end else if (target_raw_c < MAX_NEG) begin
      target_c   = MAX_NEG;
      plan_sat_c = 1'b1;
    end
    diff_c     = target_c - pv_c;
    plan_up_c  = (target_c > pv_c);
    plan_rem_c = diff_c[PHASE_W] ? PHASE_W'(-diff_c) : diff_c[PHASE_W-1:0];
  end

  always_comb begin
    state_next   = state;
    step_start_c = 1'b0;
    unique case (state)
      IDLE: if (accept_c) state_next = PLAN;
      PLAN: begin
        if (plan_rem_c == '0) begin
          state_next = FINISH;
        end else begin
          state_next   = ASSERT;
          step_start_c = 1'b1;
        end
      end
      ASSERT: begin
        if (step_done) begin
          if (remaining != PHASE_W'(1)) step_start_c = 1'b1;
          else                          state_next   = FINISH;
        end else if (step_fail) begin
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge rx_clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op_q        <= '0;
      value_q     <= '0;
      remaining   <= '0;
      phase_value <= '0;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      cmd_done    <= 1'b0;
      saturated   <= 1'b0;
    end else begin
      state     <= state_next;
      cmd_ready <= (state_next == IDLE);
      busy      <= (state_next != IDLE);
      cmd_done  <= (state_next == FINISH);
      if (accept_c) begin
        op_q      <= cmd_op;
        value_q   <= cmd_value;
        saturated <= 1'b0;
      end
      if (state == PLAN) begin
        remaining <= plan_rem_c;
        saturated <= plan_sat_c;
      end
      if (state == ASSERT && step_done) begin
        remaining   <= remaining - PHASE_W'(1);
        phase_value <= phaseupdown ? phase_value + PHASE_W'(1) : phase_value - PHASE_W'(1);
      end
    end
  end

`ifdef PHASE_TIMEOUT_EN
  always_ff @(posedge rx_clock or negedge reset_n) begin
    if (!reset_n)                                      timeout_err <= 1'b0;
    else if (accept_c)                                 timeout_err <= 1'b0;
    else if (state == ASSERT && step_fail && !step_done) timeout_err <= 1'b1;
  end
`else
  assign timeout_err = 1'b0;
`endif

  pll_phase_step #(
    .STEP_HOLD      (STEP_HOLD),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_step (
    .clk         (rx_clock),
    .rst_n       (reset_n),
    .start       (step_start_c),
    .up          (step_up_c),
    .phasedone   (phasedone),
    .phasestep   (phasestep),
    .phaseupdown (phaseupdown),
    .done        (step_done),
    .fail        (step_fail)
  );

endmodule

// File: doc/pll_phase_sequencer.md
Name: pll_phase_sequencer

Overview:
- Owns the altpll dynamic-phase-shift port on behalf of the Ethernet command path.
- Accepts one phase command at a time: step down, step up, set to an absolute value, or return to zero.
- Issues the required number of single phasestep/phasedone handshakes to the PLL, one step = 4.5 deg.
- Tracks the signed phase offset and reports completion, saturation and PLL timeout to the command decoder.

Parameters:
- STEP_HOLD, 5, cycles phasestep is held high per step (must be >= 2).
- MAX_STEPS, 80, magnitude limit of the phase offset in steps (80 = 360 deg); must be <= 127.
- TIMEOUT_CYCLES, 4096, cycles allowed for phasedone to complete one step (used only with PHASE_TIMEOUT_EN).

Ports:
- rx_clock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  0 step-down, 1 step-up, 2 set, 3 reset-to-zero
- cmd_value  in  8  signed two's-complement target for op 2; ignored otherwise
- phasedone  in  1  from PLL; low while a step is in progress
- phasestep  out  1  to PLL
- phaseupdown  out  1  to PLL; 1 = up, 0 = down
- phase_value  out  8  signed current offset in steps
- busy  out  1  high outside IDLE
- cmd_done  out  1  one-cycle pulse when a command finishes, including a saturated or failed one
- saturated  out  1  sticky until the next accept; set when a request was clipped at ±MAX_STEPS
- timeout_err  out  1  sticky until the next accept; tied 0 without PHASE_TIMEOUT_EN

Behaviour:
- Reset values:
  - phasestep=0, phaseupdown=0, phase_value=0, busy=0, cmd_done=0, saturated=0, timeout_err=0, cmd_ready=0.
  - State = IDLE; cmd_ready rises on the first clock after reset release.
  - Reset mid-step drops phasestep immediately. The PLL is reset by the same system reset, so phase_value=0 is consistent with it.
- States: IDLE, PLAN, ASSERT, WAIT_LOW, WAIT_HIGH, FINISH.
- IDLE:
  - cmd_ready=1.
  - On accept: latch op/value, clear saturated and timeout_err, go to PLAN.
  - A command arriving while busy is held off (cmd_ready=0) and never dropped.
- PLAN (1 cycle): 9-bit signed arithmetic. target =
  - op0: phase_value-1
  - op1: phase_value+1
  - op2: cmd_value
  - op3: 0
- Clamping:
  - The target is clamped to [-MAX_STEPS, +MAX_STEPS]; saturated=1 if the clamp changed it.
  - cmd_value=-128 clamps to -MAX_STEPS.
- Step plan:
  - remaining = |target - phase_value|, 8-bit unsigned, max 2*MAX_STEPS.
  - phaseupdown = (target > phase_value).
  - If remaining = 0, go to FINISH with no PLL activity.
- ASSERT:
  - phasestep=1 for exactly STEP_HOLD cycles, then go to WAIT_LOW.
  - phaseupdown is stable from PLAN until FINISH.
- WAIT_LOW / WAIT_HIGH:
  - Wait for phasedone=0. If phasedone=0 was already seen during ASSERT, skip straight to WAIT_HIGH.
  - Then wait for phasedone=1.
  - On the phasedone rise:
    - phase_value += ±1 (registered the same cycle);
    - remaining -= 1;
    - if remaining ≠ 0, go to ASSERT, else FINISH.
- FINISH: cmd_done=1 for one cycle, return to IDLE.
- Latency:
  - A single step with an ideal PLL (phasedone low for 1 cycle, high the next) completes in 1+STEP_HOLD+3 cycles from accept to cmd_done.
  - A zero-step command completes in 3 cycles.
- phase_value never leaves [-MAX_STEPS, +MAX_STEPS]. No wrap-around: at +MAX_STEPS a step-up produces saturated=1 and a cmd_done with no PLL step.

Optional Feature:
- Macro: PHASE_TIMEOUT_EN.
- Defined:
  - A counter restarts at each ASSERT entry and counts through WAIT_LOW/WAIT_HIGH.
  - On reaching TIMEOUT_CYCLES: timeout_err=1, abandon the remaining steps, phase_value keeps the last confirmed value, go to FINISH, cmd_done pulses.
- Undefined: no counter; WAIT states wait indefinitely; timeout_err is constant 0.

Decomposition:
- Shared package pll_phase_pkg holds:
  - op-code constants (OP_STEP_DOWN=0, OP_STEP_UP=1, OP_SET=2, OP_RESET=3);
  - the state encoding;
  - PHASE_DEG_PER_STEP (4.5 deg, documentation constant).
- One sub-module, pll_phase_step: performs a single ASSERT/WAIT_LOW/WAIT_HIGH handshake, including the optional timeout. Its ports are start, up, done, fail.
- The top level keeps PLAN/FINISH, the offset register and the flags.

Test Plan:
- PLL model (phasedone low 3 cycles after phasestep, then high). Step-up with phase_value=0 -> one phasestep pulse exactly 5 cycles wide, phaseupdown=1, phase_value=1, one cmd_done.
- Set cmd_value=-3 from phase_value=2 -> 5 pulses with phaseupdown=0, phase_value=-3, saturated=0.
- Set cmd_value=100 (MAX_STEPS=80) from 0 -> 80 pulses, phase_value=80, saturated=1. A following step-up -> no pulse, cmd_done, saturated=1.
- Reset-to-zero from phase_value=-7 -> 7 up pulses, phase_value=0. A second reset-to-zero -> cmd_done after 3 cycles with no pulse.
- cmd_valid held during a 5-step set -> cmd_ready=0 until FINISH; the queued step-down is then accepted once and executed once.
- PHASE_TIMEOUT_EN, TIMEOUT_CYCLES=16, phasedone stuck low after 2nd of 4 steps -> timeout_err=1, phase_value=1, cmd_done. Assert reset_n=0 mid-step -> phasestep=0 immediately, all outputs at reset values.
